// File: rtl/main_fsm.sv
// Multi-cycle controller sequencer: a Moore FSM that walks each instruction through
// fetch, decode and its opcode-specific execute/memory/writeback states.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    output logic       Branch,
    output logic       PCUpdate,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       AdrSrc,
    output logic [1:0] ALUOp,
    output logic       InstrDone,
    output logic       Illegal,
    output logic [3:0] state_o
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    state_t state_q, state_d;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTER;
                    OP_ITYPE:     state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    OP_LUI:       state_d = LUI;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR:   state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = MEMWB;
            EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Outputs decode the state register only; reset masks the enables so no
    // write can land in the cycle reset is raised.
    always_comb begin
        Branch    = 1'b0;
        PCUpdate  = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        AdrSrc    = 1'b0;
        ALUOp     = 2'b00;
        InstrDone = 1'b0;
        Illegal   = 1'b0;
        case (state_q)
            FETCH: begin
                IRWrite = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10; PCUpdate = 1'b1;
            end
            DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01;
            end
            MEMREAD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01; RegWrite = 1'b1; InstrDone = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1; MemWrite = 1'b1; InstrDone = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10; ALUOp = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10;
            end
            ALUWB: begin
                RegWrite = 1'b1; InstrDone = 1'b1;
            end
            BEQ: begin
                ALUSrcA = 2'b10; ALUOp = 2'b01; Branch = 1'b1; InstrDone = 1'b1;
            end
            JAL: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCUpdate = 1'b1;
            end
            LUI: begin
                ResultSrc = 2'b11; RegWrite = 1'b1; InstrDone = 1'b1;
            end
            TRAP:     Illegal = 1'b1;
            default:  ;
        endcase
        if (reset) begin
            IRWrite   = 1'b0;
            PCUpdate  = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            Branch    = 1'b0;
            InstrDone = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed scenarios plus random instruction streams, checked
// against a per-opcode state-sequence and per-state output table.
module tb_main_fsm;

    logic       clk, reset;
    logic [6:0] op;
    logic       Branch, PCUpdate, RegWrite, MemWrite, IRWrite, AdrSrc, InstrDone, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [3:0] state_o;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           BQ = 7'b1100011, IT = 7'b0010011, JL = 7'b1101111,
                           LU = 7'b0110111;

    main_fsm dut (
        .clk(clk), .reset(reset), .op(op),
        .Branch(Branch), .PCUpdate(PCUpdate), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .AdrSrc(AdrSrc), .ALUOp(ALUOp), .InstrDone(InstrDone), .Illegal(Illegal),
        .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [15:0] dut_out = {Branch, PCUpdate, RegWrite, MemWrite, IRWrite, ResultSrc,
                           ALUSrcA, ALUSrcB, AdrSrc, ALUOp, InstrDone, Illegal};

    // Expected control word for a state, as listed in the output table.
    function automatic logic [15:0] ref_out(int s, bit rst);
        logic br, pcu, rw, mw, irw, adr, idn, ill;
        logic [1:0] rs, sa, sb, aop;
        {br, pcu, rw, mw, irw, adr, idn, ill} = '0;
        {rs, sa, sb, aop} = '0;
        case (s)
            0:  begin irw = 1; sb = 2'b10; rs = 2'b10; pcu = 1; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1;
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2'b10; aop = 2'b10; end
            7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            8:  rw = 1;
            9:  begin sa = 2'b10; aop = 2'b01; br = 1; end
            10: begin sa = 2'b01; sb = 2'b10; pcu = 1; end
            11: begin rs = 2'b11; rw = 1; end
            12: ill = 1;
            default: ;
        endcase
        idn = (s == 4 || s == 5 || s == 8 || s == 9 || s == 11);
        if (rst) {irw, pcu, rw, mw, br, idn} = '0;
        return {br, pcu, rw, mw, irw, rs, sa, sb, adr, aop, idn, ill};
    endfunction

    // i-th state of the instruction with opcode o, or -1 past its last state.
    function automatic int ref_state(logic [6:0] o, int i);
        int s[5];
        int len;
        s = '{0, 1, 12, 0, 0}; len = 3;
        case (o)
            LW: begin s = '{0, 1, 2, 3, 4};  len = 5; end
            SW: begin s = '{0, 1, 2, 5, 0};  len = 4; end
            RT: begin s = '{0, 1, 6, 8, 0};  len = 4; end
            IT: begin s = '{0, 1, 7, 8, 0};  len = 4; end
            JL: begin s = '{0, 1, 10, 8, 0}; len = 4; end
            BQ: begin s = '{0, 1, 9, 0, 0};  len = 3; end
            LU: begin s = '{0, 1, 11, 0, 0}; len = 3; end
            default: ;
        endcase
        return (i < len) ? s[i] : -1;
    endfunction

    // Apply inputs, check at the falling edge, advance to just after the next rising edge.
    task automatic step(int exp_s, logic [6:0] op_v, bit rst, string tag);
        logic [15:0] exp_o;
        op    = op_v;
        reset = rst;
        exp_o = ref_out(exp_s, rst);
        @(negedge clk);
        n_assert++;
        assert (state_o === 4'(exp_s)) else begin
            n_fail++;
            $error("FAIL %s state: got %0d expected %0d", tag, state_o, exp_s);
        end
        n_assert++;
        assert (dut_out === exp_o) else begin
            n_fail++;
            $error("FAIL %s outputs in state %0d: got %h expected %h", tag, exp_s, dut_out, exp_o);
        end
        @(posedge clk);
        #1;
    endtask

    // Run one instruction; op is only meaningful in DECODE/MEMADR, so scramble it elsewhere.
    task automatic run_instr(logic [6:0] o, int max_states, string tag);
        int s;
        for (int i = 0; i < max_states; i++) begin
            s = ref_state(o, i);
            if (s < 0) break;
            step(s, (s == 1 || s == 2) ? o : 7'($urandom), 1'b0, tag);
        end
    endtask

    function automatic bit is_legal(logic [6:0] o);
        return o == LW || o == SW || o == RT || o == IT || o == JL || o == BQ || o == LU;
    endfunction

    initial begin
        logic [6:0] legal[7];
        logic [6:0] r;
        legal = '{LW, SW, RT, IT, JL, BQ, LU};
        reset = 1'b1;
        op    = 7'd0;
        @(posedge clk);
        #1;
        step(0, 7'd0, 1'b1, "reset_hold");

        // sw up to MEMWRITE, then reset for three cycles starting in that state
        run_instr(SW, 3, "pre_reset_sw");
        step(5, SW, 1'b1, "reset_in_memwrite");
        step(0, SW, 1'b1, "reset_cyc2");
        step(0, SW, 1'b1, "reset_cyc3");

        run_instr(LW, 5, "lw");
        run_instr(SW, 5, "sw");
        run_instr(RT, 5, "rtype");
        run_instr(BQ, 5, "beq");
        run_instr(JL, 5, "jal");
        run_instr(LU, 5, "lui");
        run_instr(IT, 5, "itype");

        run_instr(7'b1111111, 5, "illegal");
        for (int i = 0; i < 10; i++) step(12, 7'($urandom), 1'b0, "trap_hold");
        step(12, LW, 1'b1, "trap_reset");

        for (int k = 0; k < 60; k++)
            run_instr(legal[$urandom_range(0, 6)], 5, "random");

        do r = 7'($urandom); while (is_legal(r));
        run_instr(r, 5, "random_illegal");
        step(12, 7'($urandom), 1'b0, "random_trap_hold");
        step(12, 7'($urandom), 1'b1, "random_trap_reset");
        step(0, 7'($urandom), 1'b0, "post_reset_fetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
# main_fsm

Moore state machine at the core of the multi-cycle controller. It sequences every instruction through Fetch, Decode and the opcode-specific execute/memory/writeback states. It drives the datapath multiplexer selects, the write enables and the ALUOp class. It sits beside the immediate-source decoder and takes the same 7-bit opcode from the instruction register. Its ALUOp feeds the ALU decoder, and its Branch/PCUpdate feed the PC-enable logic.

## Interface
- No parameters. Opcode encodings are fixed: lw 0000011, sw 0100011, r_type 0110011, beq 1100011, i_type_alu 0010011, jal 1101111, lui 0110111.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- op  input  7  opcode field of the instruction register
- Branch  output  1  branch-compare state
- PCUpdate  output  1  unconditional PC write
- RegWrite  output  1  register file write enable
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register (and OldPC) load
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 A (RD1)
- ALUSrcB  output  2  00 WriteData (RD2), 01 ImmExt, 10 constant 4
- AdrSrc  output  1  0 PC, 1 Result
- ALUOp  output  2  00 add, 01 subtract, 10 funct-decoded
- InstrDone  output  1  one-cycle pulse in the final state of each instruction
- Illegal  output  1  high while in TRAP
- state_o  output  4  current state encoding, for debug and verification

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, LUI 11, TRAP 12. Encodings 13–15 go to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - DECODE on op: lw/sw→MEMADR, r_type→EXECUTER, i_type_alu→EXECUTEI, beq→BEQ, jal→JAL, lui→LUI, any other→TRAP.
  - MEMADR: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER, EXECUTEI, JAL→ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BEQ, LUI→FETCH.
  - TRAP→TRAP until reset.
- op is used only in DECODE and MEMADR. The IR is stable from the end of FETCH until the next FETCH.
- Moore outputs. Any signal not listed for a state is 0, including selects.
  - FETCH: AdrSrc=0, IRWrite, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate.
  - LUI: ResultSrc=11, RegWrite.
  - TRAP: Illegal=1, all enables 0.
- InstrDone is high in MEMWB, MEMWRITE, ALUWB (and therefore for jal), BEQ and LUI.

## Timing
- State register updates on the rising edge of clk. All outputs are combinational decodes of the state register; there is no input-to-output path.
- Reset: a clk edge with reset=1 sets state=FETCH. While reset is high, IRWrite, PCUpdate, RegWrite, MemWrite, Branch and InstrDone are forced to 0 regardless of state. After reset drops, the first cycle is a full FETCH.
- Reset asserted mid-instruction (e.g. in MEMWRITE): enables drop in that same cycle and state is FETCH after the edge. No partial write completes.
- Cycles per instruction, FETCH to last state inclusive: lw 5, sw 4, r_type 4, i_type_alu 4, jal 4, beq 3, lui 3.
- Back-to-back instructions: the last state is followed immediately by FETCH. There are no idle cycles.
- An op change outside DECODE/MEMADR has no effect.

## Test plan
- Reset held 3 cycles in state 5 → enables 0 during reset; state_o=0 and IRWrite=PCUpdate=1 in the first post-reset cycle.
- op=0000011 → state_o sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; InstrDone pulses once.
- op=0100011, then 0110011 back-to-back → 0,1,2,5,0,1,6,8,0; MemWrite only in state 5, AdrSrc=1; ALUOp=10 in state 6.
- op=1100011 → 0,1,9,0; Branch=1 and ALUOp=01 in state 9.
- op=1101111, then 0110111 → 0,1,10,8,0,1,11,0; PCUpdate in state 10; ResultSrc=11 with RegWrite in state 11.
- op=1111111 → 0,1,12 and stays in 12 for 10 cycles with Illegal=1 and all enables 0; reset returns to 0.
